// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one W-bit register between two writers; grant one edge after request, write one edge after grant.
// No backpressure: a losing requester simply waits, and the owner is forced out after MAXHOLD cycles under contention.
module dff_bank_arbiter #(
    parameter int W       = 4,
    parameter int MAXHOLD = 4
) (
    input  logic         C,
    input  logic         R,
    input  logic         REQ0,
    input  logic         REQ1,
    input  logic [W-1:0] D0,
    input  logic [W-1:0] D1,
    output logic         GNT0,
    output logic         GNT1,
    output logic         BUSY,
    output logic [W-1:0] Q,
    output logic [W-1:0] nQ
);
    localparam int CW = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXHOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic [W-1:0]    bank_q, bank_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        bank_d  = bank_q;
        case (state_q)
            IDLE: begin
                // last_q names the requester served most recently; the other wins a tie
                if (REQ0 && REQ1) begin
                    state_d = last_q ? OWN0 : OWN1;
                    cnt_d   = '0;
                end else if (REQ0) begin
                    state_d = OWN0;
                    cnt_d   = '0;
                end else if (REQ1) begin
                    state_d = OWN1;
                    cnt_d   = '0;
                end
            end
            OWN0: begin
                if (REQ0) begin
                    bank_d = D0;
                end
                if (!REQ0 && REQ1) begin
                    state_d = OWN1;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else if (!REQ0) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end else if (REQ1 && cnt_q == CNT_MAX) begin
                    state_d = OWN1;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OWN1: begin
                if (REQ1) begin
                    bank_d = D1;
                end
                if (!REQ1 && REQ0) begin
                    state_d = OWN0;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end else if (!REQ1) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end else if (REQ0 && cnt_q == CNT_MAX) begin
                    state_d = OWN0;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            bank_q  <= bank_d;
        end
    end

    assign GNT0 = (state_q == OWN0);
    assign GNT1 = (state_q == OWN1);
    assign BUSY = GNT0 | GNT1;
    assign Q    = bank_q;
    assign nQ   = ~bank_q;
endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Two-requester arbiter that shares one W-bit storage register (a bank of D flip-flops) between two writers.
- Grants exclusive ownership with round-robin tie-breaking and a bounded hold time for fairness.
- Drives the bank's load/data path and exposes the stored value as Q and nQ.
- Sits between two producers and the shared state register in gate-level test designs.

Parameters:
- W, 4, data width of the shared register and of each requester's data bus.
- MAXHOLD, 4, maximum consecutive grant cycles while the other side is requesting; legal range >= 1.

Ports:
- C  input  1  clock; all state changes on the rising edge.
- R  input  1  reset; synchronous, active-high.
- REQ0  input  1  requester 0 wants ownership / write.
- REQ1  input  1  requester 1 wants ownership / write.
- D0  input  W  requester 0 write data.
- D1  input  W  requester 1 write data.
- GNT0  output  1  requester 0 owns the register.
- GNT1  output  1  requester 1 owns the register.
- BUSY  output  1  either grant is active.
- Q  output  W  stored register value.
- nQ  output  W  bitwise complement of Q, always.

Behaviour:
- Reset: one C edge with R=1 sets:
  - state IDLE, Q=0 (nQ all ones), GNT0=GNT1=BUSY=0;
  - hold counter cnt=0, LAST=1, so requester 0 wins the first tie.
  - R overrides all requests. A reset mid-grant aborts the grant, and no write occurs on that edge.
- States are IDLE, OWN0 and OWN1. Outputs are Moore:
  - GNT0 = (state==OWN0); GNT1 = (state==OWN1); BUSY = GNT0|GNT1.
  - GNT0 and GNT1 are never both 1.
- IDLE transitions:
  - REQ0&REQ1 -> OWN of the requester other than LAST.
  - Single REQx -> OWNx.
  - None -> stay.
  - cnt=0 on every entry to an OWN state.
  - Latency: request seen at edge k -> GNT high after edge k.
- Write rule: at any edge where state==OWNx and REQx=1 and R=0, Q <= Dx.
  - First write lands one edge after the grant appears.
  - No write in IDLE or when the owner has dropped REQ.
- OWNx transitions (y = other requester), evaluated in priority order:
  - REQx=0 and REQy=1 -> OWNy, LAST=x, cnt=0. No idle gap.
  - REQx=0 and REQy=0 -> IDLE, LAST=x.
  - REQy=1 and cnt==MAXHOLD-1 -> OWNy, LAST=x, cnt=0. This is a forced handover; the write from Dx on this edge still occurs.
  - Otherwise stay in OWNx; cnt increments, saturating at MAXHOLD-1.
- Uncontested owner: keeps the grant indefinitely. If REQy rises while cnt is saturated, handover happens on the next edge.
- MAXHOLD=1: under continuous contention the grant alternates every cycle.
- Counter width: ceil(log2(MAXHOLD)), minimum 1 bit.
- Q holds its value whenever no write occurs. nQ tracks Q combinationally.

Test Plan (W=4, MAXHOLD=4):
1. Reset with priority tie:
   - Stimulus: R=1 for 2 edges with REQ0=REQ1=1, D0=1111; then R=0.
   - During reset: Q=0000, nQ=1111, GNT0=GNT1=BUSY=0.
   - First edge after release: GNT0=1.
   - Next edge: Q=1111.
2. Single requester:
   - Stimulus: REQ1=1, D1=1010 sampled at edge k.
   - After edge k: GNT1=1, BUSY=1. After edge k+1: Q=1010, nQ=0101.
   - REQ1=0 at edge k+2: IDLE after k+2, Q stays 1010.
3. Sustained contention:
   - Stimulus: REQ0=REQ1=1, D0=0011, D1=1100 from IDLE.
   - Grant sequence: GNT0 for exactly 4 cycles, GNT1 for 4 cycles, repeating.
   - Q: 0011 during GNT0 windows (from the 2nd cycle on), 1100 during GNT1 windows (from the 2nd cycle on).
   - GNT0 and GNT1 never overlap.
4. Early release:
   - Stimulus: REQ0 drops after 2 GNT0 cycles while REQ1=1.
   - Response: GNT1=1 on the very next cycle, BUSY stays 1, Q keeps the last D0 until D1 is written.
5. Reset mid-operation:
   - Stimulus: R=1 during the 3rd cycle of OWN1, with D1 changed.
   - Response: after that edge, IDLE, Q=0000, no D1 write.
   - Then REQ0=REQ1=1 -> GNT0 first.
6. Uncontested saturation:
   - Stimulus: REQ0=1 for 10 cycles, REQ1=0; then REQ1=1.
   - Response: GNT0 held throughout the 10 cycles; GNT1 appears 1 cycle after REQ1 is sampled.
